// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: round-robin arbiter sequencing START/ADDR/data/STOP commands on a shared byte-level I2C engine
module i2c_txn_sequencer #(
  parameter int NREQ  = 2,
  parameter int LEN_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_rw,
  input  logic [NREQ*7-1:0]     req_addr,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic [NREQ*8-1:0]     wr_data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       wr_take,
  output logic [7:0]            rd_data,
  output logic [NREQ-1:0]       rd_valid,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic                  eng_cmd_valid,
  output logic [2:0]            eng_cmd,
  output logic [7:0]            eng_wdata,
  input  logic                  eng_cmd_ready,
  input  logic                  eng_done,
  input  logic                  eng_nack,
  input  logic [7:0]            eng_rdata
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [3:0] {
    IDLE, START_I, START_W, ADDR_I, ADDR_W, WR_I, WR_W, RD_I, RD_W, STOP_I, STOP_W, FIN
  } state_t;
  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d, rd_valid_q, rd_valid_d;
  logic [IW-1:0]    ptr_q, ptr_d, win;
  logic             found, rw_q, rw_d, err_q, err_d;
  logic [6:0]       addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [7:0]       rd_data_q, rd_data_d;
  assign gnt      = gnt_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  // search begins just past the last winner so every requester gets a turn
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req_valid[IW'((int'(ptr_q) + k) % NREQ)]) begin
        found = 1'b1;
        win   = IW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    ptr_d         = ptr_q;
    rw_d          = rw_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = '0;
    eng_cmd_valid = 1'b0;
    eng_cmd       = 3'd0;
    eng_wdata     = 8'h00;
    wr_take       = '0;
    done          = '0;
    err           = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        state_d = START_I;
        gnt_d   = NREQ'(1) << win;
        ptr_d   = win;
        rw_d    = req_rw[win];
        addr_d  = req_addr[win*7 +: 7];
        len_d   = req_len[win*LEN_W +: LEN_W];
      end
      START_I: begin
        eng_cmd_valid = 1'b1;
        eng_cmd       = 3'd1;
        state_d       = eng_cmd_ready ? START_W : START_I;
      end
      START_W: state_d = eng_done ? ADDR_I : START_W;
      ADDR_I: begin
        eng_cmd_valid = 1'b1;
        eng_cmd       = 3'd2;
        eng_wdata     = {addr_q, rw_q};
        state_d       = eng_cmd_ready ? ADDR_W : ADDR_I;
      end
      ADDR_W: if (eng_done) begin
        cnt_d   = len_q;
        err_d   = eng_nack;
        state_d = (eng_nack || len_q == '0) ? STOP_I : (rw_q ? RD_I : WR_I);
      end
      WR_I: begin
        eng_cmd_valid = 1'b1;
        eng_cmd       = 3'd2;
        eng_wdata     = wr_data[ptr_q*8 +: 8];
        wr_take       = eng_cmd_ready ? gnt_q : '0;
        state_d       = eng_cmd_ready ? WR_W : WR_I;
      end
      WR_W: if (eng_done) begin
        cnt_d   = cnt_q - 1'b1;
        err_d   = eng_nack;
        state_d = (eng_nack || cnt_q == LEN_W'(1)) ? STOP_I : WR_I;
      end
      RD_I: begin
        eng_cmd_valid = 1'b1;
        eng_cmd       = (cnt_q == LEN_W'(1)) ? 3'd4 : 3'd3;
        state_d       = eng_cmd_ready ? RD_W : RD_I;
      end
      RD_W: if (eng_done) begin
        rd_data_d  = eng_rdata;
        rd_valid_d = gnt_q;
        cnt_d      = cnt_q - 1'b1;
        state_d    = (cnt_q == LEN_W'(1)) ? STOP_I : RD_I;
      end
      STOP_I: begin
        eng_cmd_valid = 1'b1;
        eng_cmd       = 3'd5;
        state_d       = eng_cmd_ready ? STOP_W : STOP_I;
      end
      STOP_W: state_d = eng_done ? FIN : STOP_W;
      FIN: begin
        done    = gnt_q;
        err     = err_q;
        gnt_d   = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ptr_q      <= IW'(NREQ - 1);
      rw_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: vector table of transactions against a behavioural engine with command/read/done scoreboards
module tb_i2c_txn_sequencer;
  localparam int NREQ  = 2;
  localparam int LEN_W = 4;
  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0, req_rw = '0;
  logic [NREQ*7-1:0]     req_addr = '0;
  logic [NREQ*LEN_W-1:0] req_len = '0;
  logic [NREQ*8-1:0]     wr_data;
  logic [NREQ-1:0]       gnt, wr_take, rd_valid, done;
  logic [7:0]            rd_data, eng_wdata, eng_rdata;
  logic                  err, eng_cmd_valid, eng_cmd_ready, eng_done, eng_nack;
  logic [2:0]            eng_cmd;
  typedef struct {int idx; bit rw; logic [6:0] addr; int len; logic [31:0] d; int nack_at; bit exp_err;} vec_t;
  typedef struct {logic [2:0] cmd; logic [7:0] wdata;} cmd_t;
  typedef struct {int idx; logic [7:0] data;} rd_t;
  typedef struct {int idx; bit err;} dn_t;
  cmd_t        cmd_q[$];
  rd_t         rd_q[$];
  dn_t         dn_q[$];
  logic [7:0]  rq[$];
  logic [31:0] wbytes [NREQ];
  int          wpos [NREQ];
  int checks = 0, errors = 0, done_cnt = 0, rd_acc = 0;
  int stall = 0, nack_at = -1, cur_idx = 0, wcount = 0, lat = 0;
  bit pending, data_wr, nack_now;
  logic [7:0] rd_now = 8'h00;
  rd_t r;
  dn_t dn;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NREQ; g++) begin : g_wd
    assign wr_data[g*8 +: 8] = wbytes[g][31-8*(wpos[g]%4) -: 8];
  end
  i2c_txn_sequencer #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_len(req_len), .wr_data(wr_data), .gnt(gnt), .wr_take(wr_take), .rd_data(rd_data),
    .rd_valid(rd_valid), .done(done), .err(err), .eng_cmd_valid(eng_cmd_valid),
    .eng_cmd(eng_cmd), .eng_wdata(eng_wdata), .eng_cmd_ready(eng_cmd_ready),
    .eng_done(eng_done), .eng_nack(eng_nack), .eng_rdata(eng_rdata)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask
  // engine side: logs each accepted command against the expected stream
  task automatic accept();
    cmd_t e;
    data_wr  = 1'b0;
    nack_now = 1'b0;
    if (cmd_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL cmd_extra: got cmd %0d, want none", eng_cmd);
    end else begin
      e = cmd_q.pop_front();
      chk("cmd", {29'd0, eng_cmd}, {29'd0, e.cmd});
      if (e.cmd == 3'd2) chk("wdata", {24'd0, eng_wdata}, {24'd0, e.wdata});
    end
    if (eng_cmd == 3'd1) wcount = 0;
    if (eng_cmd == 3'd2) begin
      nack_now = (wcount == nack_at);
      data_wr  = (wcount > 0);
      wcount++;
    end
    if (eng_cmd == 3'd3 || eng_cmd == 3'd4) begin
      rd_now = (rq.size() > 0) ? rq.pop_front() : 8'h00;
      rd_acc++;
    end
    #1 chk("wr_take", {30'd0, wr_take}, data_wr ? (32'd1 << cur_idx) : 32'd0);
    if (data_wr) begin
      @(posedge clk);
      #1 wpos[cur_idx]++;
    end
  endtask
  initial begin
    eng_cmd_ready = 1'b0;
    eng_done      = 1'b0;
    eng_nack      = 1'b0;
    eng_rdata     = 8'h00;
    pending       = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        eng_cmd_ready = 1'b0;
        eng_done      = 1'b0;
        eng_nack      = 1'b0;
        pending       = 1'b0;
      end else begin
        if (eng_done) begin
          eng_done = 1'b0;
          eng_nack = 1'b0;
          pending  = 1'b0;
        end
        if (pending) begin
          eng_cmd_ready = 1'b0;
          if (lat > 0) lat--;
          else begin
            eng_done  = 1'b1;
            eng_nack  = nack_now;
            eng_rdata = rd_now;
          end
        end else if (eng_cmd_valid && stall > 0) begin
          eng_cmd_ready = 1'b0;
          stall--;
          chk("stall_hold", {28'd0, eng_cmd_valid, eng_cmd}, 32'h9);
        end else if (eng_cmd_valid) begin
          eng_cmd_ready = 1'b1;
          pending       = 1'b1;
          lat           = 2;
          accept();
        end else eng_cmd_ready = 1'b0;
      end
    end
  end
  always @(negedge clk) begin
    if (!rst && |rd_valid) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_extra: got rd_valid %0h, want none", rd_valid);
      end else begin
        r = rd_q.pop_front();
        chk("rd_valid", {30'd0, rd_valid}, 32'd1 << r.idx);
        chk("rd_data", {24'd0, rd_data}, {24'd0, r.data});
      end
    end
    if (!rst && |done) begin
      if (dn_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_extra: got done %0h, want none", done);
      end else begin
        dn = dn_q.pop_front();
        chk("done", {30'd0, done}, 32'd1 << dn.idx);
        chk("err", {31'd0, err}, {31'd0, dn.err});
        chk("gnt_at_done", {30'd0, gnt}, 32'd1 << dn.idx);
      end
      done_cnt++;
    end
  end
  task automatic push_exp(input vec_t v);
    logic [7:0] b;
    cmd_q.push_back('{3'd1, 8'h00});
    cmd_q.push_back('{3'd2, {v.addr, v.rw}});
    if (v.nack_at != 0) begin
      for (int i = 0; i < v.len; i++) begin
        b = v.d[31-8*i -: 8];
        if (v.rw) begin
          cmd_q.push_back('{(i == v.len - 1) ? 3'd4 : 3'd3, 8'h00});
          rd_q.push_back('{v.idx, b});
          rq.push_back(b);
        end else begin
          cmd_q.push_back('{3'd2, b});
          if (v.nack_at == i + 1) break;
        end
      end
    end
    cmd_q.push_back('{3'd5, 8'h00});
    dn_q.push_back('{v.idx, v.exp_err});
  endtask
  task automatic drive(input vec_t v);
    req_rw[v.idx]                 = v.rw;
    req_addr[v.idx*7 +: 7]        = v.addr;
    req_len[v.idx*LEN_W +: LEN_W] = LEN_W'(v.len);
    wbytes[v.idx]                 = v.d;
    wpos[v.idx]                   = 0;
    nack_at                       = v.nack_at;
    cur_idx                       = v.idx;
    req_valid[v.idx]              = 1'b1;
  endtask
  task automatic wait_done(input int target);
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (done_cnt >= target) break;
    end
    chk("txn_complete", {31'd0, done_cnt >= target}, 32'd1);
  endtask
  task automatic run_txn(input vec_t v);
    push_exp(v);
    drive(v);
    wait_done(done_cnt + 1);
    req_valid[v.idx] = 1'b0;
  endtask
  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_gnt"}, {30'd0, gnt}, 32'd0);
    chk({nm, "_cmd"}, {20'd0, eng_cmd_valid, eng_cmd, eng_wdata}, 32'd0);
    chk({nm, "_pulses"}, {26'd0, wr_take, rd_valid, done}, 32'd0);
    chk({nm, "_rd"}, {23'd0, err, rd_data}, 32'd0);
  endtask
  vec_t vecs [5];
  vec_t pv, rv, f0, f1;
  int base;
  initial begin
    vecs[0] = '{0, 1'b0, 7'h50, 2, 32'hA53C0000, -1, 1'b0};
    vecs[1] = '{1, 1'b1, 7'h21, 3, 32'h11223300, -1, 1'b0};
    vecs[2] = '{0, 1'b0, 7'h7F, 4, 32'hDEADBEEF,  0, 1'b1};
    vecs[3] = '{1, 1'b0, 7'h33, 3, 32'h01020300,  2, 1'b1};
    vecs[4] = '{0, 1'b1, 7'h0A, 1, 32'h5A000000, -1, 1'b0};
    pv      = '{1, 1'b0, 7'h2A, 0, 32'h0, -1, 1'b0};
    rv      = '{1, 1'b1, 7'h21, 3, 32'h11223300, -1, 1'b0};
    f0      = '{0, 1'b0, 7'h10, 0, 32'h0, -1, 1'b0};
    f1      = '{1, 1'b0, 7'h11, 0, 32'h0, -1, 1'b0};
    for (int i = 0; i < NREQ; i++) begin
      wbytes[i] = 32'h0;
      wpos[i]   = 0;
    end
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) run_txn(vecs[i]);
    stall = 5;
    run_txn(pv);
    chk("stall_used", stall, 0);
    push_exp(rv);
    drive(rv);
    base = rd_acc;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #2;
      if (rd_acc > base) break;
    end
    chk("rd_wait_reached", {31'd0, rd_acc > base}, 32'd1);
    rst = 1'b1;
    #1 chk_outputs_zero("midreset");
    req_valid = '0;
    repeat (2) @(negedge clk);
    cmd_q.delete();
    rd_q.delete();
    dn_q.delete();
    rq.delete();
    @(negedge clk);
    rst = 1'b0;
    push_exp(f0);
    push_exp(f1);
    push_exp(f0);
    push_exp(f1);
    drive(f0);
    drive(f1);
    wait_done(done_cnt + 4);
    req_valid = '0;
    repeat (10) @(negedge clk);
    chk("cmd_q_empty", cmd_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("dn_q_empty", dn_q.size(), 0);
    chk("idle_after", {31'd0, eng_cmd_valid}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
